// File: rtl/transpose_stream_buffer.sv
// rtl/transpose_stream_buffer.sv - ping-pong NUM_PE x NUM_PE block buffer with transpose/bypass readout
//
// Purpose:
//   Collects NUM_PE rows of NUM_PE elements into one of two banks, then
//   streams the block back out either transposed (columns become rows) or
//   unchanged. While one bank drains, the other fills, so a producer and a
//   consumer that never stall see one beat per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_row/in_mode/in_last are valid
//   in_ready   a row can be accepted this cycle
//   in_row     row r of the block being written, element c at index c
//   in_mode    1 = transpose, 0 = bypass; only taken on the first row
//   in_last    producer end-of-block marker, checked against the row count
//   out_valid  out_row holds a valid beat
//   out_ready  consumer accepts the beat
//   out_row    output beat, zero when out_valid is low
//   out_last   final beat of the block
//   out_mode   mode captured for the block being read
//   err        sticky framing error, cleared only by rst
module transpose_stream_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row [0:NUM_PE-1],
  input  logic                  in_mode,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_row [0:NUM_PE-1],
  output logic                  out_last,
  output logic                  out_mode,
  output logic                  err
);

  localparam int CNT_W = $clog2(NUM_PE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PE - 1);

  // bank[b][row][col]; contents are deliberately left unreset.
  logic [DATA_WIDTH-1:0] bank [0:1][0:NUM_PE-1][0:NUM_PE-1];

  logic [1:0]       full;
  logic [1:0]       mode;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;

  logic in_fire;
  logic out_fire;
  logic wr_at_last;
  logic rd_at_last;

  assign in_ready   = !full[wr_bank];
  assign out_valid  = full[rd_bank];
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign wr_at_last = (wr_cnt == LAST_CNT);
  assign rd_at_last = (rd_cnt == LAST_CNT);

  assign out_last = out_valid && rd_at_last;
  assign out_mode = mode[rd_bank];

  // Read mux: transpose walks column rd_cnt down the rows, bypass reads row
  // rd_cnt directly. Outputs depend only on registered state, so they hold
  // steady under backpressure without an extra output register.
  for (genvar j = 0; j < NUM_PE; j++) begin : g_out
    assign out_row[j] = !out_valid         ? '0 :
                        mode[rd_bank]      ? bank[rd_bank][j][rd_cnt] :
                                             bank[rd_bank][rd_cnt][j];
  end

  // A bank is only written while not full and only read while full, so the
  // write and read sides never touch the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank[wr_bank][wr_cnt] <= in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      mode    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      if (in_fire) begin
        if (wr_cnt == '0) begin
          mode[wr_bank] <= in_mode;
        end
        // in_last must coincide exactly with the internal final row; the
        // block boundary itself is still decided by wr_cnt.
        if (in_last != wr_at_last) begin
          err <= 1'b1;
        end
        if (wr_at_last) begin
          wr_cnt        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (out_fire) begin
        if (rd_at_last) begin
          rd_cnt        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_stream_buffer.sv
// tb/tb_transpose_stream_buffer.sv - scoreboard bench for transpose_stream_buffer
module tb_transpose_stream_buffer;

  localparam int DW = 16;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_row [0:NP-1];
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_row [0:NP-1];
  logic          out_last;
  logic          out_mode;
  logic          err;

  transpose_stream_buffer #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .out_mode(out_mode), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] row;
    logic        last;
    logic        mode;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    run = 0;
  int    max_run = 0;

  function automatic logic [63:0] pack_out();
    logic [63:0] r;
    for (int j = 0; j < NP; j++) r[16*j +: 16] = out_row[j];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected beats straight from the block definition: element(r,c) = base+16r+c.
  task automatic push_block(input logic [15:0] base, input logic md);
    beat_t e;
    for (int k = 0; k < NP; k++) begin
      for (int j = 0; j < NP; j++)
        e.row[16*j +: 16] = md ? base + 16'(16*j + k) : base + 16'(16*k + j);
      e.last = (k == NP - 1);
      e.mode = md;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops and compares on every output handshake, tracks runs of
  // back-to-back handshakes.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got row=%h last=%b mode=%b expected no beat", pack_out(), out_last, out_mode);
      end else begin
        e = sb.pop_front();
        if ({pack_out(), out_last, out_mode} !== {e.row, e.last, e.mode}) begin
          miscompares++;
          $display("FAIL out_beat: got row=%h last=%b mode=%b expected row=%h last=%b mode=%b",
                   pack_out(), out_last, out_mode, e.row, e.last, e.mode);
        end
      end
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  // Drives one row; call at posedge+1, returns at posedge+1 after the handshake.
  task automatic send_beat(input logic [15:0] base, input int r, input logic md,
                           input logic lst, output int stalls);
    int n = 0;
    in_valid = 1'b1;
    for (int c = 0; c < NP; c++) in_row[c] = base + 16'(16*r + c);
    in_mode = md;
    in_last = lst;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
    end
    stalls = n;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [15:0] base, input logic md, input int last_pos,
                            output int stalls, output logic [3:0] ov_tr, output logic [3:0] err_tr);
    int st;
    stalls = 0;
    push_block(base, md);
    for (int r = 0; r < NP; r++) begin
      send_beat(base, r, md, (r == last_pos), st);
      stalls += st;
      ov_tr[r]  = out_valid;
      err_tr[r] = err;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    logic [3:0] ov_tr, err_tr;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < NP; c++) in_row[c] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_row", pack_out(), 64'd0);
    check("rst_out_last_mode_err", {61'd0, out_last, out_mode, err}, 64'd0);

    // Block 1: transpose, element(r,c)=16r+c
    out_ready = 1'b1;
    send_block(16'h0000, 1'b1, 3, stalls, ov_tr, err_tr);
    in_valid = 1'b0;
    check("t1_out_valid_trace", 64'(ov_tr), 64'b1000);
    check("t1_beat0_row", pack_out(), 64'h0030_0020_0010_0000);
    check("t1_err_trace", 64'(err_tr), 64'd0);
    wait_drain();

    // Block 2: bypass
    send_block(16'h0000, 1'b0, 3, stalls, ov_tr, err_tr);
    in_valid = 1'b0;
    wait_drain();
    check("t2_err", 64'(err), 64'd0);

    // Back-to-back A (transpose) and B (bypass)
    max_run = 0;
    send_block(16'h0100, 1'b1, 3, stalls, ov_tr, err_tr);
    check("t3_a_stalls", 64'(stalls), 64'd0);
    send_block(16'h0200, 1'b0, 3, stalls, ov_tr, err_tr);
    check("t3_b_stalls", 64'(stalls), 64'd0);
    in_valid = 1'b0;
    wait_drain();
    check("t3_contiguous_beats", 64'(max_run), 64'd8);

    // Backpressure: two blocks fill both banks, third is refused
    out_ready = 1'b0;
    send_block(16'h0300, 1'b1, 3, stalls, ov_tr, err_tr);
    send_block(16'h0400, 1'b0, 3, stalls, ov_tr, err_tr);
    check("t4_accept_stalls", 64'(stalls), 64'd0);
    in_valid = 1'b1;
    for (int c = 0; c < NP; c++) in_row[c] = 16'h0500 + 16'(c);
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t4_in_ready_blocked", 64'(in_ready), 64'd0);
      check("t4_held_row", pack_out(), 64'h0330_0320_0310_0300);
      check("t4_held_valid_last_mode", {61'd0, out_valid, out_last, out_mode}, 64'b101);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t4_in_ready_before_free", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("t4_in_ready_after_free", 64'(in_ready), 64'd1);
    send_block(16'h0500, 1'b1, 3, stalls, ov_tr, err_tr);
    in_valid = 1'b0;
    wait_drain();

    // Framing error: in_last on beat 1 (and missing on beat 3)
    send_block(16'h0600, 1'b1, 1, stalls, ov_tr, err_tr);
    in_valid = 1'b0;
    check("t5_err_trace", 64'(err_tr), 64'b1110);
    wait_drain();
    check("t5_err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_err_cleared", 64'(err), 64'd0);

    // Reset mid-stream: one full block, one output beat, two input beats
    out_ready = 1'b0;
    send_block(16'h0700, 1'b1, 3, stalls, ov_tr, err_tr);
    out_ready = 1'b1;
    send_beat(16'h0800, 0, 1'b0, 1'b0, stalls);
    out_ready = 1'b0;
    send_beat(16'h0800, 1, 1'b0, 1'b0, stalls);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_row", pack_out(), 64'd0);
    out_ready = 1'b1;
    send_block(16'h0900, 1'b1, 3, stalls, ov_tr, err_tr);
    in_valid = 1'b0;
    check("t6_out_valid_trace", 64'(ov_tr), 64'b1000);
    wait_drain();

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transpose_stream_buffer.md
Name: transpose_stream_buffer

Overview:
- Streaming successor to the per-stage transpose switch: accepts NUM_PE-element rows over a valid/ready handshake and buffers one full NUM_PE x NUM_PE block.
- Emits the block either transposed (columns as rows) or unchanged (bypass).
- Two ping-pong banks allow sustained one-beat-per-cycle throughput.
- Sits between the MG/PE datapaths, in place of a chain of fixed-control switch stages.

Parameters:
- DATA_WIDTH, 64, width of one element.
- NUM_PE, 8, elements per row and rows per block; must be >= 2.
- CNT_W, $clog2(NUM_PE), beat counter width (localparam).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_row/in_mode/in_last valid.
- in_ready  output  1  buffer can accept a row this cycle.
- in_row  input  [DATA_WIDTH-1:0] x NUM_PE (unpacked [0:NUM_PE-1])  row r of block; element c at index c.
- in_mode  input  1  1 = transpose, 0 = bypass; sampled on first beat of a block only.
- in_last  input  1  producer's end-of-block marker, checked against the internal count.
- out_valid  output  1  out_row holds a valid beat.
- out_ready  input  1  consumer accepts beat.
- out_row  output  [DATA_WIDTH-1:0] x NUM_PE (unpacked [0:NUM_PE-1])  output beat k.
- out_last  output  1  high on beat NUM_PE-1 of a block.
- out_mode  output  1  mode latched for the block being read.
- err  output  1  sticky framing error.

Behaviour:
- State: bank[2][NUM_PE][NUM_PE], full[2], mode[2], wr_bank, rd_bank, wr_cnt, rd_cnt.
- Reset:
  - full, wr_bank, rd_bank, wr_cnt, rd_cnt, mode, err cleared.
  - Bank contents are not reset.
  - Outputs after reset: in_ready=1, out_valid=0, out_row all 0, out_last=0, out_mode=0, err=0.
  - Reset mid-block discards all partial and full blocks.
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: bank[wr_bank][wr_cnt] <= in_row. When wr_cnt==0, mode[wr_bank] <= in_mode.
  - wr_cnt increments. At wr_cnt==NUM_PE-1: wr_cnt wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Read side:
  - out_valid = full[rd_bank].
  - Beat k = rd_cnt.
    - Transpose: out_row[j] = bank[rd_bank][j][k].
    - Bypass: out_row[j] = bank[rd_bank][k][j].
  - out_row forced to 0 when !out_valid. out_last = out_valid && rd_cnt==NUM_PE-1. out_mode = mode[rd_bank].
  - On out_valid && out_ready: rd_cnt increments. At NUM_PE-1: rd_cnt wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- Latency and throughput:
  - First out_valid is the cycle after the handshake of input beat NUM_PE-1.
  - A freed bank shows in_ready the cycle after its final read handshake. There is no same-cycle free-and-fill.
  - With in_valid and out_ready held high, throughput is 1 beat/cycle with no bubbles.
- Backpressure:
  - out_row, out_last and out_mode stay stable while out_valid && !out_ready.
  - When both banks are full, in_ready=0 until a block completes reading.
- Simultaneous events: a write to wr_bank and a read from rd_bank in the same cycle are independent. A bank is never written while full, so there is no read/write conflict.
- Framing:
  - err <= 1 if an accepted beat has in_last=1 with wr_cnt!=NUM_PE-1, or in_last=0 with wr_cnt==NUM_PE-1.
  - Block boundaries still follow wr_cnt.
  - err clears only on rst.
- Mode change mid-block (in_mode toggling on beats 1..NUM_PE-1) is ignored.

Test Plan:
- NUM_PE=4, DATA_WIDTH=16. Stream one block with in_mode=1, element(r,c)=16*r+c, in_last on beat 3, out_ready=1 -> out_valid rises 1 cycle after input beat 3. Beat k has out_row[j]=16*j+k, e.g. beat1={1,17,33,49}. out_last on beat 3 only, out_mode=1, err=0.
- Same block with in_mode=0 -> beat k out_row[j]=16*k+j. Beat2={32,33,34,35}.
- Back-to-back blocks A (transpose) and B (bypass), in_valid and out_ready constantly 1 -> in_ready never drops. 8 output beats are contiguous with no gap. out_mode is 1 for A's beats, then 0 for B's.
- out_ready=0 while 3 blocks are offered -> 2 blocks accepted (8 beats), then in_ready=0. out_row is held at A beat0. Raising out_ready drains A; in_ready returns 1 cycle after A's beat-3 handshake.
- in_last on beat 1 of a block -> err=1 from next cycle and stays 1. The block still completes after 4 beats with correct data. rst clears err.
- Assert rst after 2 input beats and 1 output beat -> next cycle: in_ready=1, out_valid=0, out_row=0. A fresh block afterwards transposes correctly.
